// File: rtl/nonce_search_controller.sv
// Nonce search sequencer: builds {header_prefix, nonce} messages, drives the SHA block,
// and compares each hash to the target. Optional DOUBLE_SHA_EN hashes the first result again.
module nonce_search_controller #(
  parameter int MSG_SIZE = 640,
  parameter int NONCE_W  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [MSG_SIZE-NONCE_W-1:0]  header_prefix_i,
  input  logic [255:0]                 target_i,
  input  logic [NONCE_W-1:0]           nonce_first_i,
  input  logic [NONCE_W-1:0]           nonce_last_i,
  output logic [MSG_SIZE-1:0]          sha_msg_o,
  output logic                         sha_begin_o,
  input  logic                         sha_complete_i,
  input  logic [255:0]                 sha_hash_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         found_o,
  output logic                         exhausted_o,
  output logic [NONCE_W-1:0]           found_nonce_o,
  output logic [255:0]                 found_hash_o,
  output logic [31:0]                  hashes_tried_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_CLR  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_COMPARE   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]                  state_q, state_d;
  logic [MSG_SIZE-NONCE_W-1:0] prefix_q, prefix_d;
  logic [255:0]                target_q, target_d;
  logic [NONCE_W-1:0]          last_q, last_d;
  logic [NONCE_W-1:0]          cur_q, cur_d;
  logic [MSG_SIZE-1:0]         msg_q, msg_d;
  logic                        begin_q, begin_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        found_q, found_d;
  logic                        exh_q, exh_d;
  logic [NONCE_W-1:0]          fnonce_q, fnonce_d;
  logic [255:0]                fhash_q, fhash_d;
  logic [31:0]                 tried_q, tried_d;
  logic [NONCE_W-1:0]          nonce_inc;
`ifdef DOUBLE_SHA_EN
  logic                        pass_q, pass_d;
`endif

  assign nonce_inc = cur_q + NONCE_W'(1);

  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    target_d = target_q;
    last_d   = last_q;
    cur_d    = cur_q;
    msg_d    = msg_q;
    begin_d  = begin_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    exh_d    = exh_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    tried_d  = tried_q;
`ifdef DOUBLE_SHA_EN
    pass_d   = pass_q;
`endif

    if (abort_i && state_q != S_IDLE) begin
      // Results were cleared at job start, so found/exhausted stay low after a cancel.
      state_d = S_IDLE;
      begin_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_d  = S_LOAD;
            prefix_d = header_prefix_i;
            target_d = target_i;
            last_d   = nonce_last_i;
            cur_d    = nonce_first_i;
            busy_d   = 1'b1;
            found_d  = 1'b0;
            exh_d    = 1'b0;
            fnonce_d = '0;
            fhash_d  = '0;
            tried_d  = '0;
          end
        end
        S_LOAD: begin
          state_d = S_ISSUE;
          msg_d   = {prefix_q, cur_q};
          begin_d = 1'b1;
`ifdef DOUBLE_SHA_EN
          pass_d  = 1'b0;
`endif
        end
        S_ISSUE: begin
          state_d = S_WAIT_CLR;
          begin_d = 1'b0;
        end
        S_WAIT_CLR: begin
          // Complete is a level left over from the previous message; wait for it to drop.
          if (!sha_complete_i) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (sha_complete_i) begin
`ifdef DOUBLE_SHA_EN
            if (!pass_q) begin
              state_d = S_ISSUE;
              msg_d   = {{(MSG_SIZE-256){1'b0}}, sha_hash_i};
              begin_d = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d = S_COMPARE;
            end
`else
            state_d = S_COMPARE;
`endif
          end
        end
        S_COMPARE: begin
          tried_d = (tried_q == 32'hFFFF_FFFF) ? tried_q : tried_q + 32'd1;
          if (sha_hash_i < target_q) begin
            state_d  = S_DONE;
            found_d  = 1'b1;
            fnonce_d = cur_q;
            fhash_d  = sha_hash_i;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end else if (cur_q == last_q) begin
            state_d = S_DONE;
            exh_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_ISSUE;
            cur_d   = nonce_inc;
            msg_d   = {prefix_q, nonce_inc};
            begin_d = 1'b1;
`ifdef DOUBLE_SHA_EN
            pass_d  = 1'b0;
`endif
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          begin_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      prefix_q <= '0;
      target_q <= '0;
      last_q   <= '0;
      cur_q    <= '0;
      msg_q    <= '0;
      begin_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      fnonce_q <= '0;
      fhash_q  <= '0;
      tried_q  <= '0;
`ifdef DOUBLE_SHA_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      target_q <= target_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      msg_q    <= msg_d;
      begin_q  <= begin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      fnonce_q <= fnonce_d;
      fhash_q  <= fhash_d;
      tried_q  <= tried_d;
`ifdef DOUBLE_SHA_EN
      pass_q   <= pass_d;
`endif
    end
  end

  assign sha_msg_o      = msg_q;
  assign sha_begin_o    = begin_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign found_o        = found_q;
  assign exhausted_o    = exh_q;
  assign found_nonce_o  = fnonce_q;
  assign found_hash_o   = fhash_q;
  assign hashes_tried_o = tried_q;

endmodule
